seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned radix-2 restoring divider; the inverse operation to the multiplier datapath in the multiplier basic library.
- Computes one quotient bit per clock using a trial subtract, built as a ripple of half/full subtractor cells.
- Hosts use a start/busy/done handshake.
- Sits beside the multiplier in the add/sub arithmetic unit; results are held until the next accepted start.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a division; sampled only in IDLE or DONE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepted start edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepted start edge.
- busy  output  1  high while an iteration is in progress (state RUN).
- done  output  1  one-cycle pulse; quotient/remainder/div_by_zero are valid from this cycle on.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; held until the next accepted start.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and internal regs cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge T:
  - Capture dividend into shift register Q and divisor into D; clear partial remainder R (WIDTH+1 bits); clear counter.
  - If divisor==0: go to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1. done is visible after edge T+1.
  - Else: go to RUN; busy=1 after edge T.
- RUN, each edge:
  - Form {R,Q} shifted left by 1. Trial T' = R_shifted − {0,D}.
  - If T' is non-negative (borrow=0): R=T', Q LSB=1. Else: R=R_shifted, Q LSB=0.
  - Counter increments.
  - On the WIDTH-th iteration (edge T+WIDTH): load quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0; go to DONE.
- Latency: done is high in the single cycle after edge T+WIDTH (non-zero divisor) or after edge T+1 (zero divisor). busy is never high in the zero-divisor case.
- DONE: done=1 for exactly one cycle.
  - start=1: accepted exactly as from IDLE (back-to-back; no idle gap required).
  - start=0: go to IDLE.
- start while RUN: ignored. Inputs may change freely during RUN without affecting the result.
- Outputs quotient/remainder/div_by_zero change only on the edge entering DONE. They are not cleared on return to IDLE. The old result remains readable during the next RUN.
- Invariant for every non-zero divisor: dividend == quotient*divisor + remainder, and remainder < divisor.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse; the partial result is discarded.
- Trial subtract uses a borrow chain WIDTH+1 bits wide; no truncation of R before compare.

Test Plan:
- Reset, then start with dividend=200, divisor=7 -> busy for 8 cycles; done one cycle after edge T+8; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5. Second start issued in the DONE cycle is accepted with no gap.
- dividend=0x5A, divisor=0 -> done after edge T+1; busy never high; quotient=0xFF, remainder=0x5A, div_by_zero=1. The next normal division clears div_by_zero.
- Start 100/3; pulse start=1 with 9/2 at cycle 3 of RUN; change inputs mid-RUN -> second start ignored; result quotient=33, remainder=1.
- Assert rst_n=0 at cycle 4 of a 200/7 run -> busy, done, quotient and remainder immediately 0; no done pulse; a fresh 200/7 afterwards gives 28 r 4.
- Random sweep, 2000 pairs (divisor≠0), WIDTH=8 and WIDTH=16 -> invariant dividend==q*d+r and r<d holds; done latency exactly WIDTH cycles after start.

Source files
------------

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned radix-2 restoring divider with start/busy/done handshake
module seq_divider #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q, d_q, r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             zdiv_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   brw;
    logic             borrow;
    logic [WIDTH-1:0] r_d, q_d;

    assign r_sh   = {r_q, q_q[WIDTH-1]};
    assign brw[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
        assign diff[i]    = r_sh[i] ^ d_q[i] ^ brw[i];
        assign brw[i + 1] = (~r_sh[i] & (d_q[i] | brw[i])) | (d_q[i] & brw[i]);
    end
    // Top cell subtracts the zero-extended divisor bit, so only the borrow survives.
    assign borrow = ~r_sh[WIDTH] & brw[WIDTH];

    // A restored remainder is always below the divisor, so WIDTH bits hold it.
    assign r_d = borrow ? r_sh[WIDTH-1:0] : diff;
    assign q_d = {q_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            zdiv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        q_q     <= dividend;
                        d_q     <= divisor;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        zdiv_q  <= (divisor == '0);
                        busy_q  <= (divisor != '0);
                        state_q <= ST_RUN;
                    end else if (state_q == ST_DONE) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Zero divisor takes one silent cycle in RUN so done lands one edge after start.
                    if (zdiv_q) begin
                        zdiv_q  <= 1'b0;
                        quot_q  <= '1;
                        rem_q   <= q_q;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        r_q   <= r_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            quot_q  <= q_d;
                            rem_q   <= r_d;
                            dbz_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and swept checks of seq_divider at WIDTH 8 and 16
module tb_seq_divider;
    localparam int W  = 8;
    localparam int W2 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [W-1:0]  dvd = '0, dvs = '0;
    logic          busy, done, dbz;
    logic [W-1:0]  quo, rem;

    logic          start2 = 1'b0;
    logic [W2-1:0] dvd2 = '0, dvs2 = '0;
    logic          busy2, done2, dbz2;
    logic [W2-1:0] quo2, rem2;

    int n_chk = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dvd), .divisor(dvs),
        .busy(busy), .done(done), .quotient(quo), .remainder(rem), .div_by_zero(dbz)
    );

    seq_divider #(.WIDTH(W2)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dividend(dvd2), .divisor(dvs2),
        .busy(busy2), .done(done2), .quotient(quo2), .remainder(rem2), .div_by_zero(dbz2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the start edge; lat counts edges until done is seen.
    task automatic wait_done(input bit sel16, output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!(sel16 ? done2 : done) && lat < 40) begin
            if (sel16 ? busy2 : busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    task automatic go8(input logic [W-1:0] a, input logic [W-1:0] d);
        dvd = a;
        dvs = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int lat, nb;
    logic [31:0] ea, ed;

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quo", quo, 0);
        check("rst_rem", rem, 0);
        check("rst_dbz", dbz, 0);
        rst_n = 1'b1;
        tick();

        go8(200, 7);
        check("200_7_busy_after_T", busy, 1);
        wait_done(0, lat, nb);
        check("200_7_lat", lat, 8);
        check("200_7_busy_cycles", nb, 8);
        check("200_7_quo", quo, 28);
        check("200_7_rem", rem, 4);
        check("200_7_dbz", dbz, 0);
        tick();
        check("200_7_done_one_cycle", done, 0);
        check("200_7_quo_held", quo, 28);

        go8(255, 1);
        wait_done(0, lat, nb);
        check("255_1_quo", quo, 255);
        check("255_1_rem", rem, 0);
        go8(5, 9);
        check("b2b_accepted_busy", busy, 1);
        check("b2b_old_result_held", quo, 255);
        wait_done(0, lat, nb);
        check("5_9_lat", lat, 8);
        check("5_9_quo", quo, 0);
        check("5_9_rem", rem, 5);

        go8(8'h5A, 0);
        check("dz_busy_after_T", busy, 0);
        wait_done(0, lat, nb);
        check("dz_lat", lat, 1);
        check("dz_busy_never", nb, 0);
        check("dz_quo", quo, 8'hFF);
        check("dz_rem", rem, 8'h5A);
        check("dz_flag", dbz, 1);
        tick();
        check("dz_done_one_cycle", done, 0);
        go8(10, 3);
        wait_done(0, lat, nb);
        check("after_dz_flag_clear", dbz, 0);
        check("10_3_quo", quo, 3);
        check("10_3_rem", rem, 1);

        go8(100, 3);
        dvd = 9;
        dvs = 2;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dvd = 77;
        dvs = 5;
        wait_done(0, lat, nb);
        check("ignore_start_lat", lat + 3, 8);
        check("ignore_start_quo", quo, 33);
        check("ignore_start_rem", rem, 1);

        go8(200, 7);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quo", quo, 0);
        check("midrst_rem", rem, 0);
        tick();
        tick();
        rst_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) nb++;
        end
        check("midrst_no_done", nb, 0);
        go8(200, 7);
        wait_done(0, lat, nb);
        check("fresh_quo", quo, 28);
        check("fresh_rem", rem, 4);

        for (int i = 0; i < 2000; i++) begin
            ea = 32'($urandom_range(0, 255));
            ed = 32'($urandom_range(1, 255));
            go8(W'(ea), W'(ed));
            wait_done(0, lat, nb);
            check("sw8_lat", lat, 8);
            check("sw8_quo", quo, ea / ed);
            check("sw8_invariant", 32'(quo) * ed + 32'(rem), ea);
            check("sw8_rem_lt_div", 32'(32'(rem) < ed), 1);
        end

        for (int i = 0; i < 2000; i++) begin
            ea = 32'($urandom_range(0, 65535));
            ed = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom_range(1, 65535));
            dvd2 = W2'(ea);
            dvs2 = W2'(ed);
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            wait_done(1, lat, nb);
            check("sw16_lat", lat, 16);
            check("sw16_quo", quo2, ea / ed);
            check("sw16_invariant", 32'(quo2) * ed + 32'(rem2), ea);
            check("sw16_rem_lt_div", 32'(32'(rem2) < ed), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
